// File: rtl/vliw_pkg.sv
// Shared widths and the writeback entry type for the VLIW datapath.
package vliw_pkg;
  localparam int DATA_W     = 16;
  localparam int NREG       = 8;
  localparam int REG_ADDR_W = $clog2(NREG);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Circular buffer for pending writebacks: up to two pushes and one pop per cycle.
module wb_fifo
  import vliw_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = $bits(wb_entry_t),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [1:0]    push_cnt,
  input  logic [W-1:0]  push_a,
  input  logic [W-1:0]  push_b,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      case (push_cnt)
        2'd1:    wr_ptr <= inc(wr_ptr);
        2'd2:    wr_ptr <= inc(inc(wr_ptr));
        default: wr_ptr <= wr_ptr;
      endcase
      if (pop) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(push_cnt) - CW'(pop);
    end
  end

  // Storage needs no reset: entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      if (push_cnt != 2'd0) mem[wr_ptr] <= push_a;
      if (push_cnt == 2'd2) mem[inc(wr_ptr)] <= push_b;
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges two issue lanes into one register write per cycle,
// with same-destination squashing, a small bypassable queue, and flush.
module wb_arbiter
  import vliw_pkg::*;
#(
  parameter int DATA_W = vliw_pkg::DATA_W,
  parameter int NREG   = vliw_pkg::NREG,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    l0_valid,
  input  logic [$clog2(NREG)-1:0] l0_addr,
  input  logic [DATA_W-1:0]       l0_data,
  input  logic                    l1_valid,
  input  logic [$clog2(NREG)-1:0] l1_addr,
  input  logic [DATA_W-1:0]       l1_data,
  output logic                    in_ready,
  output logic [NREG-1:0]         wr_en,
  output logic [DATA_W-1:0]       wr_data,
  output logic                    busy
);
  localparam int AW = $clog2(NREG);
  localparam int EW = AW + DATA_W;
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] count;
  logic [EW-1:0] fifo_head, push_a, push_b, first_e, second_e, out_e;
  logic [1:0]    push_cnt, n_acc;
  logic          acc0, acc1, pop_fifo, emit;

  assign in_ready = rst_n && !flush && (count <= CW'(DEPTH - 2));

  // Program order: lane 1 is the later write, so it wins a shared destination.
  assign acc0 = in_ready && l0_valid && !(l1_valid && (l0_addr == l1_addr));
  assign acc1 = in_ready && l1_valid;
  assign n_acc = 2'(acc0) + 2'(acc1);

  always_comb begin
    first_e  = acc0 ? {l0_addr, l0_data} : {l1_addr, l1_data};
    second_e = {l1_addr, l1_data};
    emit     = (count != '0) || (n_acc != 2'd0);
    pop_fifo = (count != '0);
    push_a   = first_e;
    push_b   = second_e;
    push_cnt = n_acc;
    out_e    = fifo_head;
    // Empty queue: the oldest new entry bypasses straight to the output.
    if (count == '0) begin
      out_e    = first_e;
      push_a   = second_e;
      push_cnt = (n_acc == 2'd2) ? 2'd1 : 2'd0;
    end
  end

  wb_fifo #(.DEPTH(DEPTH), .W(EW), .CW(CW)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push_cnt (push_cnt),
    .push_a   (push_a),
    .push_b   (push_b),
    .pop      (pop_fifo),
    .head     (fifo_head),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en   <= '0;
      wr_data <= '0;
    end else if (flush || !emit) begin
      wr_en   <= '0;
    end else begin
      wr_en   <= NREG'(1) << out_e[EW-1:DATA_W];
      wr_data <= out_e[DATA_W-1:0];
    end
  end

  assign busy = (count != '0) || (wr_en != '0);
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic        l0_valid, l1_valid;
  logic [2:0]  l0_addr, l1_addr;
  logic [15:0] l0_data, l1_data;
  logic        in_ready, busy;
  logic [7:0]  wr_en;
  logic [15:0] wr_data;

  int n_cmp = 0;
  int n_err = 0;

  wb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .l0_valid(l0_valid), .l0_addr(l0_addr), .l0_data(l0_data),
    .l1_valid(l1_valid), .l1_addr(l1_addr), .l1_data(l1_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [2:0] a0, input logic [15:0] d0,
                       input logic v1, input logic [2:0] a1, input logic [15:0] d1);
    l0_valid = v0; l0_addr = a0; l0_data = d0;
    l1_valid = v1; l1_addr = a1; l1_data = d1;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    idle();
    tick(); tick();
    check("rst_wr_en", wr_en, 8'h00);
    check("rst_wr_data", wr_data, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);

    // single write
    drive(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0);
    tick(); idle();
    check("single_wr_en", wr_en, 8'b0000_1000);
    check("single_wr_data", wr_data, 16'h1234);
    check("single_busy", busy, 1'b1);
    tick();
    check("single_done_wr_en", wr_en, 8'h00);
    check("single_done_busy", busy, 1'b0);
    check("single_hold_data", wr_data, 16'h1234);

    // dual write
    drive(1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'hBBBB);
    tick(); idle();
    check("dual0_wr_en", wr_en, 8'b0000_0010);
    check("dual0_wr_data", wr_data, 16'hAAAA);
    tick();
    check("dual1_wr_en", wr_en, 8'b0000_0100);
    check("dual1_wr_data", wr_data, 16'hBBBB);
    tick();
    check("dual_done_wr_en", wr_en, 8'h00);
    check("dual_done_busy", busy, 1'b0);

    // same-address conflict
    drive(1'b1, 3'd5, 16'h0001, 1'b1, 3'd5, 16'h0002);
    tick(); idle();
    check("conf_wr_en", wr_en, 8'b0010_0000);
    check("conf_wr_data", wr_data, 16'h0002);
    tick();
    check("conf_single_wr_en", wr_en, 8'h00);
    check("conf_busy", busy, 1'b0);

    // back-pressure
    drive(1'b1, 3'd0, 16'h0010, 1'b1, 3'd1, 16'h0011);
    tick();
    check("bp1_wr_en", wr_en, 8'h01);
    check("bp1_wr_data", wr_data, 16'h0010);
    check("bp1_in_ready", in_ready, 1'b1);
    drive(1'b1, 3'd2, 16'h0012, 1'b1, 3'd3, 16'h0013);
    tick();
    check("bp2_wr_en", wr_en, 8'h02);
    check("bp2_wr_data", wr_data, 16'h0011);
    check("bp2_in_ready", in_ready, 1'b1);
    drive(1'b1, 3'd4, 16'h0014, 1'b1, 3'd5, 16'h0015);
    tick();
    check("bp3_wr_en", wr_en, 8'h04);
    check("bp3_wr_data", wr_data, 16'h0012);
    check("bp3_in_ready", in_ready, 1'b0);
    drive(1'b1, 3'd6, 16'h0016, 1'b1, 3'd7, 16'h0017);
    tick(); idle();
    check("bp4_wr_en", wr_en, 8'h08);
    check("bp4_wr_data", wr_data, 16'h0013);
    check("bp4_in_ready", in_ready, 1'b1);
    tick();
    check("bp5_wr_en", wr_en, 8'h10);
    check("bp5_wr_data", wr_data, 16'h0014);
    tick();
    check("bp6_wr_en", wr_en, 8'h20);
    check("bp6_wr_data", wr_data, 16'h0015);
    tick();
    check("bp7_wr_en", wr_en, 8'h00);
    check("bp7_busy", busy, 1'b0);
    tick();
    check("bp8_wr_en", wr_en, 8'h00);

    // flush with a queued backlog and a request presented during flush
    drive(1'b1, 3'd1, 16'h0021, 1'b1, 3'd2, 16'h0022);
    tick();
    drive(1'b1, 3'd3, 16'h0023, 1'b1, 3'd4, 16'h0024);
    tick();
    check("fl_pre_wr_en", wr_en, 8'h04);
    check("fl_pre_busy", busy, 1'b1);
    drive(1'b1, 3'd7, 16'h0027, 1'b0, 3'd0, 16'h0);
    flush = 1'b1;
    #1;
    check("fl_in_ready", in_ready, 1'b0);
    tick();
    flush = 1'b0; idle();
    check("fl_wr_en", wr_en, 8'h00);
    check("fl_busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_after_wr_en", wr_en, 8'h00);
    end

    // reset mid-operation
    drive(1'b1, 3'd1, 16'h0031, 1'b1, 3'd2, 16'h0032);
    tick();
    drive(1'b1, 3'd3, 16'h0033, 1'b1, 3'd4, 16'h0034);
    tick(); idle();
    check("mr_pre_wr_en", wr_en, 8'h04);
    rst_n = 1'b0;
    #1;
    check("mr_in_ready_low", in_ready, 1'b0);
    tick();
    check("mr_wr_en", wr_en, 8'h00);
    check("mr_busy", busy, 1'b0);
    check("mr_wr_data", wr_data, 16'h0000);
    rst_n = 1'b1;
    #1;
    check("mr_in_ready_rel", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mr_after_wr_en", wr_en, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
